// File: rtl/pmod_ad1_pkg.sv
// Shared types and constants for the PmodAD1 dual-channel ADC reader.
// The optional lead-zero check is enabled with PMOD_AD1_LEAD_ZERO_CHECK_EN.
package pmod_ad1_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        QUIET   = 2'd2
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int DATA_W     = 12;
    // Bit counter walks the SCLK half-periods of one frame (two per bit).
    localparam int HALF_CNT_W = $clog2(2 * FRAME_BITS);

    function automatic logic [FRAME_BITS-1:0] shift_in(
        input logic [FRAME_BITS-1:0] frame,
        input logic                  sdata
    );
        return (frame << 1) | {{(FRAME_BITS-1){1'b0}}, sdata};
    endfunction

    function automatic logic lead_nonzero(input logic [FRAME_BITS-1:0] frame);
        return |frame[FRAME_BITS-1 -: LEAD_ZEROS];
    endfunction

endpackage

// File: rtl/pmod_ad1_reader_sclk_gen.sv
// SCLK generator: half-period divider plus rise and frame-end strobes.
// Strobes are asserted in the cycle before the clk edge they refer to.
module pmod_sclk_gen
    import pmod_ad1_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic launch,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_CNT_W-1:0] HALF_LAST = HALF_CNT_W'(2 * FRAME_BITS - 1);

    logic [DIV_W-1:0]      div_cnt_r;
    logic [HALF_CNT_W-1:0] half_cnt_r;
    logic                  sclk_r;
    logic                  half_end_s;

    // Decode half-period boundaries from the counters.
    always_comb begin
        half_end_s = en && (div_cnt_r == DIV_LAST);
        rise_tick  = half_end_s && !sclk_r;
        frame_done = half_end_s && (half_cnt_r == HALF_LAST);
    end

    // Divider and SCLK register; SCLK parks high whenever not converting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_r     <= 1'b1;
            div_cnt_r  <= {DIV_W{1'b0}};
            half_cnt_r <= {HALF_CNT_W{1'b0}};
        end else if (launch) begin
            sclk_r     <= 1'b0;
            div_cnt_r  <= {DIV_W{1'b0}};
            half_cnt_r <= {HALF_CNT_W{1'b0}};
        end else if (frame_done) begin
            sclk_r     <= 1'b1;
            div_cnt_r  <= {DIV_W{1'b0}};
            half_cnt_r <= {HALF_CNT_W{1'b0}};
        end else if (half_end_s) begin
            sclk_r     <= ~sclk_r;
            div_cnt_r  <= {DIV_W{1'b0}};
            half_cnt_r <= half_cnt_r + HALF_CNT_W'(1);
        end else if (en) begin
            div_cnt_r  <= div_cnt_r + DIV_W'(1);
        end else begin
            sclk_r     <= 1'b1;
            div_cnt_r  <= {DIV_W{1'b0}};
            half_cnt_r <= {HALF_CNT_W{1'b0}};
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/pmod_ad1_reader.sv
// PmodAD1 reader: drives NCS/SCLK and captures two 12-bit samples per frame.
// Define PMOD_AD1_LEAD_ZERO_CHECK_EN to add the frame_err lead-zero check.
module pmod_ad1_reader
    import pmod_ad1_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              SDATA1,
    input  logic              SDATA2,
    output logic              SCLK,
    output logic              NCS,
    output logic [DATA_W-1:0] ch1_data,
    output logic [DATA_W-1:0] ch2_data,
    output logic              valid,
    output logic              busy
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
    ,
    output logic              frame_err
`endif
);

    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    state_t                  state_r;
    logic [QW-1:0]           quiet_cnt_r;
    logic [FRAME_BITS-1:0]   shift1_r;
    logic [FRAME_BITS-1:0]   shift2_r;
    logic                    ncs_r;
    logic                    valid_r;
    logic                    busy_r;
    logic [DATA_W-1:0]       ch1_r;
    logic [DATA_W-1:0]       ch2_r;
    logic                    launch_s;
    logic                    en_s;
    logic                    rise_tick_s;
    logic                    frame_done_s;
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
    logic                    frame_err_r;
`endif

    // start is only honoured in IDLE, so requests while busy are dropped.
    always_comb begin
        launch_s = (state_r == IDLE) && start;
        en_s     = (state_r == CONVERT);
    end

    pmod_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst),
        .launch     (launch_s),
        .en         (en_s),
        .sclk       (SCLK),
        .rise_tick  (rise_tick_s),
        .frame_done (frame_done_s)
    );

    // Conversion FSM with shift registers and registered sample outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            quiet_cnt_r <= {QW{1'b0}};
            shift1_r    <= {FRAME_BITS{1'b0}};
            shift2_r    <= {FRAME_BITS{1'b0}};
            ncs_r       <= 1'b1;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            ch1_r       <= {DATA_W{1'b0}};
            ch2_r       <= {DATA_W{1'b0}};
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
            frame_err_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (start) begin
                        state_r  <= CONVERT;
                        ncs_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        shift1_r <= {FRAME_BITS{1'b0}};
                        shift2_r <= {FRAME_BITS{1'b0}};
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                CONVERT: begin
                    valid_r <= 1'b0;
                    if (frame_done_s) begin
                        state_r     <= QUIET;
                        ncs_r       <= 1'b1;
                        valid_r     <= 1'b1;
                        quiet_cnt_r <= {QW{1'b0}};
                        ch1_r       <= shift1_r[DATA_W-1:0];
                        ch2_r       <= shift2_r[DATA_W-1:0];
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
                        frame_err_r <= lead_nonzero(shift1_r) | lead_nonzero(shift2_r);
`endif
                    end else if (rise_tick_s) begin
                        shift1_r <= shift_in(shift1_r, SDATA1);
                        shift2_r <= shift_in(shift2_r, SDATA2);
                    end else begin
                        state_r  <= CONVERT;
                    end
                end
                QUIET: begin
                    valid_r <= 1'b0;
                    if (quiet_cnt_r == QUIET_LAST) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        quiet_cnt_r <= {QW{1'b0}};
                    end else begin
                        quiet_cnt_r <= quiet_cnt_r + QW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ncs_r   <= 1'b1;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign NCS      = ncs_r;
    assign valid    = valid_r;
    assign busy     = busy_r;
    assign ch1_data = ch1_r;
    assign ch2_data = ch2_r;
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
    assign frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_pmod_ad1_reader.sv
// Directed bench for pmod_ad1_reader with a behavioural two-converter model.
// Build with PMOD_AD1_LEAD_ZERO_CHECK_EN defined to also check frame_err.
module tb_pmod_ad1_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        SDATA1;
    logic        SDATA2;
    logic        SCLK;
    logic        NCS;
    logic [11:0] ch1_data;
    logic [11:0] ch2_data;
    logic        valid;
    logic        busy;
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
    logic        frame_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pmod_ad1_reader #(
        .CLK_DIV      (4),
        .QUIET_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .SDATA1   (SDATA1),
        .SDATA2   (SDATA2),
        .SCLK     (SCLK),
        .NCS      (NCS),
        .ch1_data (ch1_data),
        .ch2_data (ch2_data),
        .valid    (valid),
        .busy     (busy)
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    // Converter model: MSB on NCS fall, next bit after each SCLK fall.
    logic [15:0] mf1 [0:31];
    logic [15:0] mf2 [0:31];
    logic [15:0] cur1 = 16'h0000;
    logic [15:0] cur2 = 16'h0000;
    logic        sd1 = 1'b0;
    logic        sd2 = 1'b0;
    int          mfi = 0;
    int          rise_cnt = 0;
    int          sclk_rises = 0;
    int          nfall = 0;
    longint      fall_t [0:63];

    assign SDATA1 = sd1;
    assign SDATA2 = sd2;

    always @(negedge NCS) begin
        cur1 = mf1[mfi % 32];
        cur2 = mf2[mfi % 32];
        mfi++;
        rise_cnt = 0;
        sd1 = cur1[15];
        sd2 = cur2[15];
        fall_t[nfall % 64] = $time;
        nfall++;
    end

    always @(posedge SCLK) begin
        rise_cnt++;
        sclk_rises++;
    end

    always @(negedge SCLK) begin
        #1;
        if (!NCS && rise_cnt > 0 && rise_cnt < 16) begin
            sd1 = cur1[15 - rise_cnt];
            sd2 = cur2[15 - rise_cnt];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle and follow the frame until valid or timeout.
    task automatic run_frame(input logic [15:0] f1, input logic [15:0] f2,
                             output int lat, output int ncs_low, output int rises);
        int base;
        mf1[mfi % 32] = f1;
        mf2[mfi % 32] = f2;
        base    = sclk_rises;
        ncs_low = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 400) begin
            if (!NCS) ncs_low++;
            @(negedge clk);
            lat++;
        end
        rises = sclk_rises - base;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] f1;
        logic [15:0] f2;
        logic [11:0] e1;
        logic [11:0] e2;
        logic        ee;
    } vec_t;

    vec_t tbl [0:5];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, ncs_low, rises, base_f, base_r, got, n;
        logic [11:0] ce1 [0:2];
        logic [11:0] ce2 [0:2];

        tbl[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123, 1'b0};
        tbl[1] = '{16'h0000, 16'h0FFF, 12'h000, 12'hFFF, 1'b0};
        tbl[2] = '{16'h0FFF, 16'h0000, 12'hFFF, 12'h000, 1'b0};
        tbl[3] = '{16'h8ABC, 16'h0123, 12'hABC, 12'h123, 1'b1};
        tbl[4] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123, 1'b0};
        tbl[5] = '{16'h0F0F, 16'h0A5A, 12'hF0F, 12'hA5A, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ncs",   {31'd0, NCS},   32'd1);
        chk("reset_sclk",  {31'd0, SCLK},  32'd1);
        chk("reset_ch1",   {20'd0, ch1_data}, 32'd0);
        chk("reset_ch2",   {20'd0, ch2_data}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy",  {31'd0, busy},  32'd0);
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].f1, tbl[i].f2, lat, ncs_low, rises);
            chk($sformatf("v%0d_latency", i), lat, 32'd128);
            chk($sformatf("v%0d_ncs_low", i), ncs_low, 32'd128);
            chk($sformatf("v%0d_sclk_rises", i), rises, 32'd16);
            chk($sformatf("v%0d_ch1", i), {20'd0, ch1_data}, {20'd0, tbl[i].e1});
            chk($sformatf("v%0d_ch2", i), {20'd0, ch2_data}, {20'd0, tbl[i].e2});
`ifdef PMOD_AD1_LEAD_ZERO_CHECK_EN
            chk($sformatf("v%0d_frame_err", i), {31'd0, frame_err}, {31'd0, tbl[i].ee});
`endif
            @(negedge clk);
            chk($sformatf("v%0d_valid_one_cycle", i), {31'd0, valid}, 32'd0);
            chk($sformatf("v%0d_hold_ch1", i), {20'd0, ch1_data}, {20'd0, tbl[i].e1});
            wait_idle($sformatf("v%0d_busy_clear", i));
        end

        // Continuous mode: three back-to-back frames with start held high.
        ce1[0] = 12'h111; ce2[0] = 12'h999;
        ce1[1] = 12'h2C3; ce2[1] = 12'h8D4;
        ce1[2] = 12'h7E5; ce2[2] = 12'h01F;
        for (int k = 0; k < 3; k++) begin
            mf1[(mfi + k) % 32] = {4'h0, ce1[k]};
            mf2[(mfi + k) % 32] = {4'h0, ce2[k]};
        end
        base_f = nfall;
        base_r = sclk_rises;
        @(negedge clk);
        start = 1'b1;
        got = 0;
        n = 0;
        while (got < 3 && n < 1000) begin
            @(negedge clk);
            n++;
            if (valid) begin
                chk($sformatf("cont%0d_ch1", got), {20'd0, ch1_data}, {20'd0, ce1[got]});
                chk($sformatf("cont%0d_ch2", got), {20'd0, ch2_data}, {20'd0, ce2[got]});
                got++;
                if (got == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("cont_valid_count", got, 32'd3);
        wait_idle("cont_busy_clear");
        repeat (20) @(negedge clk);
        chk("cont_ncs_falls", nfall - base_f, 32'd3);
        chk("cont_period_1", 32'(fall_t[(base_f + 1) % 64] - fall_t[base_f % 64]), 32'd1370);
        chk("cont_period_2", 32'(fall_t[(base_f + 2) % 64] - fall_t[(base_f + 1) % 64]), 32'd1370);
        chk("cont_sclk_rises", sclk_rises - base_r, 32'd48);

        // A start pulse during CONVERT must not queue a second frame.
        mf1[mfi % 32] = 16'h0321;
        mf2[mfi % 32] = 16'h0654;
        base_f = nfall;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        got = 0;
        while (got == 0 && lat < 400) begin
            if (lat == 40) start = 1'b1;
            if (lat == 41) start = 1'b0;
            if (valid) got++;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("busy_latency", lat, 32'd128);
        chk("busy_ch1", {20'd0, ch1_data}, 32'h321);
        chk("busy_ch2", {20'd0, ch2_data}, 32'h654);
        wait_idle("busy_busy_clear");
        repeat (20) @(negedge clk);
        chk("busy_ncs_falls", nfall - base_f, 32'd1);

        // Reset asserted at clock 60 of a frame.
        mf1[mfi % 32] = 16'h0FFF;
        mf2[mfi % 32] = 16'h0FFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_ncs",  {31'd0, NCS},  32'd1);
        chk("rst_mid_sclk", {31'd0, SCLK}, 32'd1);
        chk("rst_mid_ch1",  {20'd0, ch1_data}, 32'd0);
        chk("rst_mid_ch2",  {20'd0, ch2_data}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        got = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (valid) got++;
        end
        rst = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (valid) got++;
        end
        chk("rst_mid_no_valid", got, 32'd0);
        run_frame(16'h0456, 16'h0789, lat, ncs_low, rises);
        chk("after_rst_latency", lat, 32'd128);
        chk("after_rst_ch1", {20'd0, ch1_data}, 32'h456);
        chk("after_rst_ch2", {20'd0, ch2_data}, 32'h789);
        wait_idle("after_rst_busy_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
